// File: rtl/pixgen_pkg.sv
// pixgen_pkg: shared display-timing defaults (1080p60 at two pixels per clock),
// pixel-pair payload type and colour-bar constants for the pixgen slice.
package pixgen_pkg;

  localparam int unsigned CTR_W = 12;
  localparam int unsigned PIX_W = 24;

  localparam int unsigned DEF_HACT  = 960;
  localparam int unsigned DEF_HFP   = 44;
  localparam int unsigned DEF_HSYNC = 22;
  localparam int unsigned DEF_HBP   = 74;
  localparam int unsigned DEF_VACT  = 1080;
  localparam int unsigned DEF_VFP   = 4;
  localparam int unsigned DEF_VSYNC = 5;
  localparam int unsigned DEF_VBP   = 36;
  localparam bit          DEF_HPOL  = 1'b1;
  localparam bit          DEF_VPOL  = 1'b1;

  // FIFO word / output pair: pixel1 in the upper half
  typedef struct packed {
    logic [PIX_W-1:0] pix1;
    logic [PIX_W-1:0] pix0;
  } pixpair_t;

  typedef enum logic [2:0] {
    BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
    BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
  } bar_e;

  localparam logic [PIX_W-1:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [PIX_W-1:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [PIX_W-1:0] COL_GREEN   = 24'h00FF00;
  localparam logic [PIX_W-1:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [PIX_W-1:0] COL_RED     = 24'hFF0000;
  localparam logic [PIX_W-1:0] COL_BLUE    = 24'h0000FF;
  localparam logic [PIX_W-1:0] COL_BLACK   = 24'h000000;

  // RGB value of one colour bar
  function automatic logic [PIX_W-1:0] bar_colour(input bar_e b);
    logic [PIX_W-1:0] c;
    c = COL_BLACK;
    unique case (b)
      BAR_WHITE:   c = COL_WHITE;
      BAR_YELLOW:  c = COL_YELLOW;
      BAR_CYAN:    c = COL_CYAN;
      BAR_GREEN:   c = COL_GREEN;
      BAR_MAGENTA: c = COL_MAGENTA;
      BAR_RED:     c = COL_RED;
      BAR_BLUE:    c = COL_BLUE;
      BAR_BLACK:   c = COL_BLACK;
      default:     c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pixgen_if.sv
// pixgen_if: FIFO read side and video output side of pixgen.
//   master (pixgen): reads fifodo/fifoempty/fiforeset, drives fiforden and
//                    pixdata/de/hsync/vsync.
//   slave  (FIFO + display sink): the opposite directions.
interface pixgen_if;
  import pixgen_pkg::*;

  pixpair_t fifodo;
  logic     fifoempty;
  logic     fiforeset;
  logic     fiforden;
  pixpair_t pixdata;
  logic     de;
  logic     hsync;
  logic     vsync;

  modport master (
    input  fifodo, fifoempty, fiforeset,
    output fiforden, pixdata, de, hsync, vsync
  );

  modport slave (
    output fifodo, fifoempty, fiforeset,
    input  fiforden, pixdata, de, hsync, vsync
  );
endinterface

// File: rtl/pixgen_vtimer.sv
// pixgen_vtimer: horizontal/vertical counter pair for the display raster.
//   clk, reset        : pixel clock, async active-high reset
//   hctr, vctr        : registered raster position (reset to first vblank line)
//   act_c             : position is inside the active region
//   hs_rgn_c/vs_rgn_c : position is inside the horizontal/vertical sync region
module pixgen_vtimer
  import pixgen_pkg::*;
#(
  parameter int unsigned HACT  = DEF_HACT,
  parameter int unsigned HFP   = DEF_HFP,
  parameter int unsigned HSYNC = DEF_HSYNC,
  parameter int unsigned HBP   = DEF_HBP,
  parameter int unsigned VACT  = DEF_VACT,
  parameter int unsigned VFP   = DEF_VFP,
  parameter int unsigned VSYNC = DEF_VSYNC,
  parameter int unsigned VBP   = DEF_VBP
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CTR_W-1:0] hctr,
  output logic [CTR_W-1:0] vctr,
  output logic             act_c,
  output logic             hs_rgn_c,
  output logic             vs_rgn_c
);

  localparam int unsigned HTOT   = HACT + HFP + HSYNC + HBP;
  localparam int unsigned VTOT   = VACT + VFP + VSYNC + VBP;
  localparam int unsigned HS_BEG = HACT + HFP;
  localparam int unsigned HS_END = HS_BEG + HSYNC;
  localparam int unsigned VS_BEG = VACT + VFP;
  localparam int unsigned VS_END = VS_BEG + VSYNC;

  logic hwrap;
  logic vwrap;

  assign hwrap = (hctr == CTR_W'(HTOT - 1));
  assign vwrap = (vctr == CTR_W'(VTOT - 1));

  // Raster counters; reset lands on the first vblank line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hctr <= '0;
      vctr <= CTR_W'(VACT);
    end else if (hwrap) begin
      hctr <= '0;
      vctr <= vwrap ? '0 : vctr + CTR_W'(1);
    end else begin
      hctr <= hctr + CTR_W'(1);
    end
  end

  assign act_c    = (hctr < CTR_W'(HACT)) && (vctr < CTR_W'(VACT));
  assign hs_rgn_c = (hctr >= CTR_W'(HS_BEG)) && (hctr < CTR_W'(HS_END));
  assign vs_rgn_c = (vctr >= CTR_W'(VS_BEG)) && (vctr < CTR_W'(VS_END));

endmodule

// File: rtl/pixgen.sv
// pixgen: display timing generator and pixel-pair source (dpclk domain).
// Drains the 48-bit framebuffer FIFO one word per active clock and emits
// pixdata with de/hsync/vsync; pulses dmastart at the start of vblank.
//   clk, reset : pixel clock, async active-high reset
//   vid        : pixgen_if.master (FIFO read side + video outputs)
//   clrerr     : clears the sticky underflow flag
//   dmastart   : one-cycle frame-fetch request
//   underflow  : sticky, set on any active cycle without FIFO data
// Optional: PIXGEN_TESTPAT_EN adds input testpat (8-bar colour pattern).
module pixgen
  import pixgen_pkg::*;
#(
  parameter int unsigned HACT  = DEF_HACT,
  parameter int unsigned HFP   = DEF_HFP,
  parameter int unsigned HSYNC = DEF_HSYNC,
  parameter int unsigned HBP   = DEF_HBP,
  parameter int unsigned VACT  = DEF_VACT,
  parameter int unsigned VFP   = DEF_VFP,
  parameter int unsigned VSYNC = DEF_VSYNC,
  parameter int unsigned VBP   = DEF_VBP,
  parameter bit          HPOL  = DEF_HPOL,
  parameter bit          VPOL  = DEF_VPOL
) (
  input  logic     clk,
  input  logic     reset,
`ifdef PIXGEN_TESTPAT_EN
  input  logic     testpat,
`endif
  pixgen_if.master vid,
  input  logic     clrerr,
  output logic     dmastart,
  output logic     underflow
);

  logic [CTR_W-1:0] hctr;
  logic [CTR_W-1:0] vctr;
  logic             act_c;
  logic             hs_rgn_c;
  logic             vs_rgn_c;
  logic             rden_c;
  logic             uf_set_c;
  logic             rdq;
  logic             de_q;
  logic             hs_q;
  logic             vs_q;

  pixgen_vtimer #(
    .HACT (HACT),  .HFP (HFP),  .HSYNC (HSYNC),  .HBP (HBP),
    .VACT (VACT),  .VFP (VFP),  .VSYNC (VSYNC),  .VBP (VBP)
  ) u_vtimer (
    .clk      (clk),
    .reset    (reset),
    .hctr     (hctr),
    .vctr     (vctr),
    .act_c    (act_c),
    .hs_rgn_c (hs_rgn_c),
    .vs_rgn_c (vs_rgn_c)
  );

`ifdef PIXGEN_TESTPAT_EN
  logic             fstart_c;
  logic             tp_mode_c;
  logic             tp_frame;
  logic             tp_q;
  bar_e             bar_c;
  logic [PIX_W-1:0] col_c;
  pixpair_t         pat_q;

  // Source is latched at frame start; the first pixel of the frame already
  // uses the live testpat value.
  assign fstart_c  = (hctr == '0) && (vctr == '0);
  assign tp_mode_c = fstart_c ? testpat : tp_frame;
  assign bar_c     = bar_e'(3'((32'(hctr) * 32'd8) / 32'(HACT)));
  assign col_c     = bar_colour(bar_c);

  assign rden_c   = act_c && !tp_mode_c && !vid.fifoempty && !vid.fiforeset;
  assign uf_set_c = act_c && !tp_mode_c && !rden_c;

  // Test-pattern stage, aligned with de
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_frame <= 1'b0;
      tp_q     <= 1'b0;
      pat_q    <= '0;
    end else begin
      if (fstart_c) tp_frame <= testpat;
      tp_q  <= act_c && tp_mode_c;
      pat_q <= '{pix1: col_c, pix0: col_c};
    end
  end

  assign vid.pixdata = tp_q ? pat_q : (rdq ? vid.fifodo : pixpair_t'('0));
`else
  assign rden_c   = act_c && !vid.fifoempty && !vid.fiforeset;
  assign uf_set_c = act_c && !rden_c;

  // fifodo is the FIFO's registered read port, so gating it with the
  // registered strobe lines pixdata up with de on the same edge.
  assign vid.pixdata = rdq ? vid.fifodo : pixpair_t'('0);
`endif

  assign vid.fiforden = rden_c;

  // Stage 1: syncs, de, read tracking, dmastart and sticky underflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdq       <= 1'b0;
      de_q      <= 1'b0;
      hs_q      <= ~HPOL;
      vs_q      <= ~VPOL;
      dmastart  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rdq       <= rden_c;
      de_q      <= act_c;
      hs_q      <= hs_rgn_c ? HPOL : ~HPOL;
      vs_q      <= vs_rgn_c ? VPOL : ~VPOL;
      dmastart  <= (hctr == '0) && (vctr == CTR_W'(VACT));
      underflow <= uf_set_c | (underflow & ~clrerr);
    end
  end

  assign vid.de    = de_q;
  assign vid.hsync = hs_q;
  assign vid.vsync = vs_q;

endmodule
